// File: rtl/barrel_sched.sv
// rtl/barrel_sched.sv - two-requester scheduler for a shared 6-stage pipelined barrel shifter
//
// Purpose: arbitrates two request streams onto one external pipelined
// shifter whose shift/rot inputs feed every stage. Operations sharing the
// current {shift, rot} stream back-to-back. A config change waits until
// every op in flight has passed the stages that read the config. Results
// come back in accept order, tagged to the requester that issued them.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   rX_valid / rX_ready        request handshake (accept = valid & ready)
//   rX_data, rX_shift, rX_rot  operand, shift amount, 1 = rotate / 0 = shift
//   rX_resp_valid              one-cycle result pulse for requester X
//   resp_data                  result (straight from sh_out)
//   sh_a, sh_shift, sh_rot     registered operand/config to the shifter
//   sh_out                     shifter result, LAT cycles after sh_a
//   busy                       any operation in flight
module barrel_sched #(
  parameter int LAT       = 6,
  parameter int MAX_BURST = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        r0_valid,
  output logic        r0_ready,
  input  logic [31:0] r0_data,
  input  logic [4:0]  r0_shift,
  input  logic        r0_rot,
  input  logic        r1_valid,
  output logic        r1_ready,
  input  logic [31:0] r1_data,
  input  logic [4:0]  r1_shift,
  input  logic        r1_rot,
  output logic        r0_resp_valid,
  output logic        r1_resp_valid,
  output logic [31:0] resp_data,
  output logic [31:0] sh_a,
  output logic [4:0]  sh_shift,
  output logic        sh_rot,
  input  logic [31:0] sh_out,
  output logic        busy
);

  localparam int QW = $clog2(LAT + 1);
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [LAT:0]  trk_v;
  logic [LAT:0]  trk_id;
  logic [QW-1:0] quiet;
  logic [BW-1:0] burst;
  logic          rr;

  logic          match0, match1, same_cfg;
  logic          m0, m1, n0, n1;
  logic          drain_ok;
  logic          gnt0, gnt1, acc, load, burst_clr, burst_inc;
  logic [31:0]   acc_data;
  logic [4:0]    acc_shift;
  logic          acc_rot;

  assign match0   = (r0_shift == sh_shift) && (r0_rot == sh_rot);
  assign match1   = (r1_shift == sh_shift) && (r1_rot == sh_rot);
  assign same_cfg = (r0_shift == r1_shift) && (r0_rot == r1_rot);
  assign m0       = r0_valid & match0;
  assign m1       = r1_valid & match1;
  assign n0       = r0_valid & ~match0;
  assign n1       = r1_valid & ~match1;

  // Once quiet reaches LAT-1 the youngest op is reading the config for the
  // last time this cycle, so a new config loaded at this edge is safe.
  assign drain_ok = (quiet >= QW'(LAT - 1));

  always_comb begin
    state_nxt = state;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    load      = 1'b0;
    burst_clr = 1'b0;
    case (state)
      IDLE: begin
        if (r0_valid && r1_valid) begin
          gnt0 = ~rr;
          gnt1 = rr;
        end else begin
          gnt0 = r0_valid;
          gnt1 = r1_valid;
        end
        if (r0_valid || r1_valid) begin
          load      = 1'b1;
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        if ((n0 || n1) && (!(m0 || m1) || burst >= BW'(MAX_BURST))) begin
          state_nxt = DRAIN;
        end else if (m0 && m1) begin
          gnt0 = ~rr;
          gnt1 = rr;
        end else begin
          gnt0 = m0;
          gnt1 = m1;
        end
        if (!r0_valid && !r1_valid && !busy) state_nxt = IDLE;
      end
      DRAIN: begin
        if (!(n0 || n1)) begin
          state_nxt = STREAM;
        end else if (drain_ok) begin
          if (n0 && n1) begin
            gnt0 = ~rr;
            gnt1 = rr;
          end else begin
            gnt0 = n0;
            gnt1 = n1;
          end
          load      = 1'b1;
          burst_clr = 1'b1;
          state_nxt = STREAM;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Ready is forced low while reset is held, even though the FSM sits in
  // IDLE where it would otherwise grant any valid request.
  assign r0_ready  = gnt0 & rst_n;
  assign r1_ready  = gnt1 & rst_n;
  assign acc       = gnt0 | gnt1;
  assign acc_data  = gnt1 ? r1_data  : r0_data;
  assign acc_shift = gnt1 ? r1_shift : r0_shift;
  assign acc_rot   = gnt1 ? r1_rot   : r0_rot;

  // The accepted op is the current config after this edge, so "the other
  // requester waits with a different config" is just a config mismatch.
  assign burst_inc = ((gnt0 & r1_valid) | (gnt1 & r0_valid)) & ~same_cfg;

  assign busy          = |trk_v;
  assign r0_resp_valid = trk_v[LAT] & ~trk_id[LAT];
  assign r1_resp_valid = trk_v[LAT] &  trk_id[LAT];
  assign resp_data     = sh_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      trk_v    <= '0;
      trk_id   <= '0;
      quiet    <= '0;
      burst    <= '0;
      rr       <= 1'b0;
      sh_a     <= '0;
      sh_shift <= '0;
      sh_rot   <= 1'b0;
    end else begin
      state  <= state_nxt;
      trk_v  <= {trk_v[LAT-1:0], acc};
      trk_id <= {trk_id[LAT-1:0], gnt1};

      if (acc) begin
        quiet <= '0;
      end else if (quiet != QW'(LAT)) begin
        quiet <= quiet + QW'(1);
      end

      if (burst_clr) begin
        burst <= '0;
      end else if (acc) begin
        if (!burst_inc) begin
          burst <= '0;
        end else if (burst != BW'(MAX_BURST)) begin
          burst <= burst + BW'(1);
        end
      end

      if (acc) begin
        rr   <= ~rr;
        sh_a <= acc_data;
      end

      if (load) begin
        sh_shift <= acc_shift;
        sh_rot   <= acc_rot;
      end
    end
  end

endmodule

// File: tb/tb_barrel_sched.sv
// tb/tb_barrel_sched.sv - scoreboard bench for barrel_sched with a behavioural shifter
module tb_barrel_sched;

  localparam int LAT = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        r0_valid, r0_ready, r0_rot;
  logic        r1_valid, r1_ready, r1_rot;
  logic [31:0] r0_data, r1_data;
  logic [4:0]  r0_shift, r1_shift;
  logic        r0_resp_valid, r1_resp_valid;
  logic [31:0] resp_data, sh_a, sh_out;
  logic [4:0]  sh_shift;
  logic        sh_rot, busy;

  always #5 clk = ~clk;

  barrel_sched dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_data(r0_data),
    .r0_shift(r0_shift), .r0_rot(r0_rot),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_data(r1_data),
    .r1_shift(r1_shift), .r1_rot(r1_rot),
    .r0_resp_valid(r0_resp_valid), .r1_resp_valid(r1_resp_valid),
    .resp_data(resp_data), .sh_a(sh_a), .sh_shift(sh_shift),
    .sh_rot(sh_rot), .sh_out(sh_out), .busy(busy)
  );

  function automatic logic [31:0] rotf(input logic [31:0] a, input logic [4:0] s, input logic r);
    logic [63:0] x;
    x = {a, a} << s;
    return r ? x[63:32] : (a << s);
  endfunction

  // External shifter: LAT register stages, config read live at the last one.
  logic [31:0] p [0:LAT-1];
  assign sh_out = p[LAT-1];
  always @(posedge clk) begin
    p[0] <= sh_a;
    for (int i = 1; i < LAT - 1; i++) p[i] <= p[i-1];
    p[LAT-1] <= rotf(p[LAT-2], sh_shift, sh_rot);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          id;
    logic [31:0] val;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   log_id[$];
  int   log_cyc[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Accept logger + response checker.
  initial begin
    logic        pend, have_last, pr;
    logic [31:0] pd;
    logic [4:0]  ps;
    logic [5:0]  last_cfg;
    int          last_cyc;
    pend = 1'b0; have_last = 1'b0; last_cyc = 0; last_cfg = '0;
    pd = '0; ps = '0; pr = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 1'b0;
        have_last = 1'b0;
      end else begin
        if (r0_resp_valid || r1_resp_valid) begin
          chk("resp_onehot", 32'(r0_resp_valid & r1_resp_valid), 32'd0);
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL resp_unexpected: got a response at cycle %0d, expected none", cyc);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("resp_id", 32'(r1_resp_valid), 32'(e.id));
            chk("resp_data", resp_data, e.val);
            chk("resp_latency", 32'(cyc - e.cyc), 32'(LAT + 1));
          end
        end
        if (pend) begin
          chk("issue_a", sh_a, pd);
          chk("issue_shift", 32'(sh_shift), 32'(ps));
          chk("issue_rot", 32'(sh_rot), 32'(pr));
          pend = 1'b0;
        end
        if (r0_valid && r0_ready && r1_valid && r1_ready) begin
          checks++;
          failures++;
          $display("FAIL double_accept: both requesters accepted at cycle %0d, expected one", cyc);
        end
        if ((r0_valid && r0_ready) || (r1_valid && r1_ready)) begin
          int id;
          id = (r1_valid && r1_ready) ? 1 : 0;
          pd = id ? r1_data  : r0_data;
          ps = id ? r1_shift : r0_shift;
          pr = id ? r1_rot   : r0_rot;
          sb.push_back('{id, rotf(pd, ps, pr), cyc});
          if (have_last && {ps, pr} != last_cfg)
            chk("cfg_change_gap_ok", 32'((cyc - last_cyc) >= LAT), 32'd1);
          have_last = 1'b1;
          last_cfg  = {ps, pr};
          last_cyc  = cyc;
          log_id.push_back(id);
          log_cyc.push_back(cyc);
          pend = 1'b1;
        end
      end
    end
  end

  task automatic send(input int id, input logic [31:0] d, input logic [4:0] s,
                      input logic r, output int waited);
    bit got;
    got = 1'b0;
    waited = 0;
    if (id == 0) begin r0_data = d; r0_shift = s; r0_rot = r; r0_valid = 1'b1; end
    else         begin r1_data = d; r1_shift = s; r1_rot = r; r1_valid = 1'b1; end
    while (!got) begin
      @(negedge clk);
      if ((id == 0) ? r0_ready : r1_ready) begin
        got = 1'b1;
      end else begin
        waited++;
        if (waited > 300) begin
          checks++;
          failures++;
          $display("FAIL send_timeout: requester %0d waited %0d cycles, expected acceptance", id, waited);
          got = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    if (id == 0) r0_valid = 1'b0;
    else         r1_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    sb.delete();
    r0_valid = 1'b1; r0_data = 32'h1234_5678; r0_shift = 5'd9;  r0_rot = 1'b1;
    r1_valid = 1'b1; r1_data = 32'h0bad_f00d; r1_shift = 5'd17; r1_rot = 1'b0;
    repeat (n) begin
      @(negedge clk);
      chk("rst_r0_ready", 32'(r0_ready), 32'd0);
      chk("rst_r1_ready", 32'(r1_ready), 32'd0);
      chk("rst_resp_valid", 32'(r0_resp_valid | r1_resp_valid), 32'd0);
      chk("rst_sh_a", sh_a, 32'd0);
      chk("rst_sh_shift", 32'(sh_shift), 32'd0);
      chk("rst_sh_rot", 32'(sh_rot), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_resp_data", resp_data, sh_out);
    end
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic single_op(input string tag);
    int w, k;
    bit seen;
    send(0, 32'h0000_0001, 5'd4, 1'b0, w);
    chk({tag, "_ready_first_cycle"}, 32'(w), 32'd0);
    @(negedge clk);
    chk({tag, "_busy_in_flight"}, 32'(busy), 32'd1);
    seen = 1'b0;
    k = 0;
    while (!seen && k < 20) begin
      if (r0_resp_valid) seen = 1'b1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    chk({tag, "_resp_seen"}, 32'(seen), 32'd1);
    chk({tag, "_resp_data"}, resp_data, 32'h0000_0010);
    @(negedge clk);
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    idle(3);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, idx, n;
    r0_valid = 1'b0; r1_valid = 1'b0;
    r0_data = '0; r1_data = '0; r0_shift = '0; r1_shift = '0; r0_rot = 1'b0; r1_rot = 1'b0;
    do_reset(3);
    idle(2);

    single_op("single");

    log_id.delete(); log_cyc.delete();
    for (int i = 0; i < 10; i++) send(0, 32'h8000_0000, 5'd3, 1'b1, w);
    chk("stream_accepts", 32'(log_id.size()), 32'd10);
    chk("stream_back_to_back", 32'(log_cyc[log_cyc.size()-1] - log_cyc[0]), 32'd9);
    idle(15);

    log_id.delete(); log_cyc.delete();
    fork
      begin for (int i = 0; i < 6; i++) begin int w0; send(0, 32'h1, 5'd1, 1'b0, w0); end end
      begin for (int j = 0; j < 6; j++) begin int w1; send(1, 32'h2, 5'd1, 1'b0, w1); end end
    join
    chk("alt_accepts", 32'(log_id.size()), 32'd12);
    for (int i = 1; i < log_id.size(); i++) chk("alt_rr_toggle", 32'(log_id[i] != log_id[i-1]), 32'd1);
    chk("alt_back_to_back", 32'(log_cyc[log_cyc.size()-1] - log_cyc[0]), 32'd11);
    idle(15);

    for (int i = 0; i < 3; i++) send(0, 32'h0000_0100 + i, 5'd2, 1'b1, w);
    repeat (3) @(posedge clk);
    #2;
    do_reset(2);
    idle(14);
    chk("post_rst_busy", 32'(busy), 32'd0);
    single_op("post_rst");

    do_reset(2);
    log_id.delete(); log_cyc.delete();
    fork
      begin for (int i = 0; i < 12; i++) begin int w0; send(0, 32'h10 + i, 5'd2, 1'b0, w0); end end
      begin int w1; send(1, 32'h0000_00a5, 5'd5, 1'b0, w1); end
    join
    idx = -1;
    for (int i = 0; i < log_id.size(); i++) if (idx < 0 && log_id[i] == 1) idx = i;
    chk("burst_r0_before_r1", 32'(idx), 32'd8);
    chk("burst_r0_consecutive", 32'(log_cyc[7] - log_cyc[0]), 32'd7);
    n = (idx > 0) ? log_cyc[idx] - log_cyc[idx-1] : -1;
    chk("burst_drain_gap", 32'(n), 32'd6);
    n = (idx > 0 && idx + 1 < log_cyc.size()) ? log_cyc[idx+1] - log_cyc[idx] : -1;
    chk("burst_return_gap", 32'(n), 32'd6);
    idle(15);

    fork
      begin
        for (int i = 0; i < 30; i++) begin
          int w0, g, c;
          g = $urandom_range(0, 3);
          c = $urandom_range(0, 2);
          if (g > 0) idle(g);
          send(0, $urandom, (c == 0) ? 5'd1 : (c == 1) ? 5'd7 : 5'd31, (c == 2), w0);
        end
      end
      begin
        for (int j = 0; j < 30; j++) begin
          int w1, g, c;
          g = $urandom_range(0, 3);
          c = $urandom_range(0, 2);
          if (g > 0) idle(g);
          send(1, $urandom, (c == 0) ? 5'd1 : (c == 1) ? 5'd7 : 5'd31, (c == 2), w1);
        end
      end
    join
    idle(20);
    chk("rand_sb_drained", 32'(sb.size()), 32'd0);
    chk("rand_busy_end", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/barrel_sched.md
Name: barrel_sched

Overview:
- Two-requester scheduler that shares one pipelined 32-bit barrel shifter (`barrelshift`: 6 register stages, shift-left, zero-fill or rotate).
- `shift` and `rot` drive every stage of that shifter directly, so the scheduler holds them constant while any operation is in flight.
- Same-config operations stream back-to-back. A config change waits for a drain.
- Results are tagged back to the issuing requester.

Parameters:
- LAT, 6, shifter register stages from `a` to `out`.
- MAX_BURST, 8, consecutive same-config accepts allowed while the other requester waits with a different config.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- r0_valid / r1_valid  in  1  request valid
- r0_ready / r1_ready  out  1  request accepted this cycle
- r0_data / r1_data  in  32  operand
- r0_shift / r1_shift  in  5  shift amount
- r0_rot / r1_rot  in  1  1 = rotate, 0 = logical shift
- r0_resp_valid / r1_resp_valid  out  1  result for that requester, one-cycle pulse
- resp_data  out  32  result, valid when either resp_valid is high
- sh_a  out  32  registered operand to shifter
- sh_shift  out  5  registered shift amount to shifter
- sh_rot  out  1  registered rotate select to shifter
- sh_out  in  32  shifter result
- busy  out  1  any operation in flight

Behaviour:
- Handshake: accept = valid & ready. A requester holds valid and payload stable until ready. Ready never depends combinationally on its own valid's payload changing. At most one accept per cycle.
- Issue: on accept in cycle T, sh_a loads data at the edge ending T. sh_shift/sh_rot load the accepted config at the same edge. The result appears on sh_out in T+1+LAT.
- Response: rX_resp_valid pulses in cycle T+1+LAT (accept-to-response = 7 cycles). resp_data = sh_out. Completions return in accept order.
- Tracking: valid/id shift register of depth LAT+1, cleared by reset. busy = OR of its bits.
- Quiet counter: cycles since last accept, saturating at LAT.
- Config hold rule: sh_shift/sh_rot change only in a cycle where quiet ≥ LAT-1. Consecutive accepts with differing config are therefore ≥ LAT cycles apart.
- A "match" means the request's {shift, rot} equals the current {sh_shift, sh_rot}.
- States:
  - IDLE: config not yet valid. Any valid request is accepted immediately and its config is loaded. If both are valid, round-robin decides. Go to STREAM.
  - STREAM: candidates are valid, matching requesters. If both match, round-robin (pointer toggles on each accept). Burst counter increments on each accept while the other requester is valid and non-matching, resets otherwise. Go to DRAIN (no accept this cycle) when a non-matching request is valid and either no matching request exists or burst ≥ MAX_BURST.
  - DRAIN: no accepts. When quiet ≥ LAT-1: accept the non-matching waiting requester, load its config, clear burst, go to STREAM.
- Return to IDLE when no request is valid and busy = 0.
- Both requesters with identical config are treated as a match, and round-robin applies.
- Reset (async, any time):
  - r*_ready = 0, r*_resp_valid = 0, resp_data passes sh_out, sh_a = 0, sh_shift = 0, sh_rot = 0, busy = 0.
  - Tracking register, quiet counter, burst counter, RR pointer (= r0) cleared. State = IDLE.
  - In-flight shifter contents are discarded and produce no response.
- Shifter semantics: out = rot ? rotl(a, shift) : a << shift (32-bit).

Test Plan:
- r0 sends 0x00000001 shift 4 rot 0 alone -> r0_ready in the cycle presented; r0_resp_valid 7 cycles later with resp_data 0x00000010; busy falls afterwards.
- r0 streams 10 ops with shift 3 rot 1 on consecutive cycles, data 0x80000000 -> one accept per cycle; 10 consecutive responses, each 0x00000004.
- r0 and r1 both hold shift 1 rot 0, data 0x1 and 0x2 -> accepts alternate r0, r1, r0, …; responses tagged in accept order, values 0x2 and 0x4.
- r0 streams shift 2 while r1 waits with shift 5 -> exactly 8 r0 accepts, then 5 idle cycles, then r1 accepted with sh_shift = 5; no r0 result corrupted.
- Reset asserted 3 cycles after 3 accepts -> no resp_valid ever pulses for them; all outputs return to reset values while rst_n is low; next request behaves as the first scenario.
